// File: rtl/ws2811_bit_serializer.sv
// ws2811_bit_serializer
// Accepts 24-bit pixel words over valid/ready and shifts them out MSB-first as
// the WS2811 NRZ waveform. Each bit is a fixed-length period: the line is high
// for T0H or T1H clocks, then low for the rest of the period. A word flagged
// last is followed by a RESET_CYCLES low latch period. Words arriving while the
// final bit of a non-last word is on the line continue with no gap.
module ws2811_bit_serializer #(
   parameter int T0H_CYCLES   = 25,
   parameter int T1H_CYCLES   = 60,
   parameter int TBIT_CYCLES  = 125,
   parameter int RESET_CYCLES = 2500
) (
   input  logic        clockIN,
   input  logic        nResetIN,
   input  logic [23:0] dataIN,
   input  logic        validIN,
   input  logic        lastIN,
   output logic        readyOUT,
   output logic        dataOUT,
   output logic        busyOUT
);

   localparam int MAX_CYCLES = (TBIT_CYCLES > RESET_CYCLES) ? TBIT_CYCLES : RESET_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(TBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] LATCH_END = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] T0H_END   = CNT_W'(T0H_CYCLES - 1);
   localparam logic [CNT_W-1:0] T1H_END   = CNT_W'(T1H_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} stateT;

   stateT            state,  stateNext;
   logic [23:0]      sh,     shNext;
   logic [4:0]       bitIdx, bitIdxNext;
   logic [CNT_W-1:0] cnt,    cntNext;
   logic             lastQ,  lastQNext;

   logic             transfer;
   logic             wordEnd;
   logic [CNT_W-1:0] highEnd;

   // Last cycle of the final bit of the current word.
   assign wordEnd  = (state == LOW) && (bitIdx == 5'd0) && (cnt == BIT_END);

   // Accept in IDLE, or on the last cycle of a non-last word so the next word follows seamlessly.
   assign readyOUT = nResetIN && ((state == IDLE) || (wordEnd && !lastQ));
   assign transfer = validIN && readyOUT;

   // Last high cycle of the bit currently on the line.
   assign highEnd  = sh[23] ? T1H_END : T0H_END;

   assign busyOUT  = (state != IDLE);

   // Next-state, shift register, bit index and cycle counter.
   always_comb begin
      // NOTE: every signal assigned here gets a default first so no path leaves it unassigned, which would infer a latch.
      stateNext  = state;
      shNext     = sh;
      bitIdxNext = bitIdx;
      cntNext    = cnt;
      lastQNext  = lastQ;

      case (state)
         IDLE: begin
            if (transfer) begin
               shNext     = dataIN;
               lastQNext  = lastIN;
               bitIdxNext = 5'd23;
               cntNext    = '0;
               stateNext  = HIGH;
            end
         end

         HIGH: begin
            cntNext = cnt + CNT_W'(1);
            if (cnt == highEnd) begin
               stateNext = LOW;
            end
         end

         LOW: begin
            if (cnt != BIT_END) begin
               cntNext = cnt + CNT_W'(1);
            end else if (bitIdx != 5'd0) begin
               shNext     = sh << 1;
               bitIdxNext = bitIdx - 5'd1;
               cntNext    = '0;
               stateNext  = HIGH;
            end else if (lastQ) begin
               cntNext   = '0;
               stateNext = LATCH;
            end else if (transfer) begin
               shNext     = dataIN;
               lastQNext  = lastIN;
               bitIdxNext = 5'd23;
               cntNext    = '0;
               stateNext  = HIGH;
            end else begin
               cntNext   = '0;
               stateNext = IDLE;
            end
         end

         LATCH: begin
            if (cnt == LATCH_END) begin
               cntNext   = '0;
               stateNext = IDLE;
            end else begin
               cntNext = cnt + CNT_W'(1);
            end
         end

         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // State register and registered line driver; synchronous reset drops the line at once.
   always_ff @(posedge clockIN) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!nResetIN) begin
         // NOTE: all registers, including the shift register, are reset; there is no memory array here to leave unreset.
         state   <= IDLE;
         sh      <= '0;
         bitIdx  <= '0;
         cnt     <= '0;
         lastQ   <= 1'b0;
         dataOUT <= 1'b0;
      end else begin
         state   <= stateNext;
         sh      <= shNext;
         bitIdx  <= bitIdxNext;
         cnt     <= cntNext;
         lastQ   <= lastQNext;
         dataOUT <= (stateNext == HIGH);
      end
   end

endmodule

// File: tb/tb_ws2811_bit_serializer.sv
// Testbench for ws2811_bit_serializer.
// The reference model is a queue of expected line samples: accepting a word
// appends its whole waveform (24 bit periods, plus the latch period when last),
// and each clock pops one sample. The serializer is ready exactly when nothing
// remains queued and the line is not in a latch period.
module tb_ws2811_bit_serializer;

   localparam int T0H    = 2;
   localparam int T1H    = 5;
   localparam int TBIT   = 8;
   localparam int RESETC = 20;

   typedef enum logic [1:0] {K_IDLE, K_BIT, K_LATCH} kindT;

   typedef struct packed {
      logic d;
      logic b;
      kindT kind;
   } sampleT;

   logic        clockIN;
   logic        nResetIN;
   logic [23:0] dataIN;
   logic        validIN;
   logic        lastIN;
   logic        readyOUT;
   logic        dataOUT;
   logic        busyOUT;

   sampleT modelQ[$];
   sampleT cur;
   logic   xfer;
   int     checks;
   int     errors;

   ws2811_bit_serializer #(
      .T0H_CYCLES   (T0H),
      .T1H_CYCLES   (T1H),
      .TBIT_CYCLES  (TBIT),
      .RESET_CYCLES (RESETC)
   ) dut (
      .clockIN  (clockIN),
      .nResetIN (nResetIN),
      .dataIN   (dataIN),
      .validIN  (validIN),
      .lastIN   (lastIN),
      .readyOUT (readyOUT),
      .dataOUT  (dataOUT),
      .busyOUT  (busyOUT)
   );

   // Free-running clock, period 10.
   initial begin
      clockIN = 1'b0;
      forever #5 clockIN = ~clockIN;
   end

   task automatic check(input string tag, input logic observed, input logic expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s at %0t: observed %b, expected %b", tag, $time, observed, expected);
      end
   endtask

   // Whole-word waveform from the bit values: high T1H or T0H clocks, low for the rest of TBIT.
   function automatic void pushWord(input logic [23:0] w, input logic l);
      sampleT s;
      for (int i = 23; i >= 0; i--) begin
         int th;
         th = w[i] ? T1H : T0H;
         for (int c = 0; c < TBIT; c++) begin
            s.d    = (c < th);
            s.b    = 1'b1;
            s.kind = K_BIT;
            modelQ.push_back(s);
         end
      end
      if (l) begin
         for (int c = 0; c < RESETC; c++) begin
            s.d    = 1'b0;
            s.b    = 1'b1;
            s.kind = K_LATCH;
            modelQ.push_back(s);
         end
      end
   endfunction

   // One clock: check ready with current inputs, advance model at the edge, check outputs mid-cycle.
   task automatic step();
      logic expReady;
      #1;
      expReady = nResetIN && (modelQ.size() == 0) && (cur.kind != K_LATCH);
      check("readyOUT", readyOUT, expReady);
      @(posedge clockIN);
      xfer = 1'b0;
      if (!nResetIN) begin
         modelQ.delete();
         cur = '{d: 1'b0, b: 1'b0, kind: K_IDLE};
      end else begin
         if (validIN && expReady) begin
            xfer = 1'b1;
            pushWord(dataIN, lastIN);
         end
         if (modelQ.size() != 0) cur = modelQ.pop_front();
         else                    cur = '{d: 1'b0, b: 1'b0, kind: K_IDLE};
      end
      @(negedge clockIN);
      check("dataOUT", dataOUT, cur.d);
      check("busyOUT", busyOUT, cur.b);
   endtask

   // Present a word and hold it until accepted (bounded), then drop valid.
   task automatic sendWord(input logic [23:0] w, input logic l);
      int n;
      validIN = 1'b1;
      dataIN  = w;
      lastIN  = l;
      n = 0;
      xfer = 1'b0;
      while (!xfer && n < 400) begin
         step();
         n++;
      end
      check("transfer_accepted", xfer, 1'b1);
      validIN = 1'b0;
   endtask

   // Run until the model has finished its waveform, plus one idle clock.
   task automatic drain();
      int n;
      n = 0;
      while ((modelQ.size() != 0 || cur.kind != K_IDLE) && n < 3000) begin
         step();
         n++;
      end
      step();
   endtask

   // Directed scenarios followed by a randomized valid/last stream.
   initial begin
      checks   = 0;
      errors   = 0;
      xfer     = 1'b0;
      cur      = '{d: 1'b0, b: 1'b0, kind: K_IDLE};
      nResetIN = 1'b0;
      validIN  = 1'b1;
      lastIN   = 1'b1;
      dataIN   = 24'($urandom());

      // Reset held with validIN high; release starts a transfer immediately.
      repeat (3) step();
      nResetIN = 1'b1;
      step();
      validIN = 1'b0;
      drain();

      // Single last word with mixed bits.
      sendWord(24'hA50F00, 1'b1);
      drain();

      // Back-to-back words, validIN held between them.
      sendWord(24'hFFFFFF, 1'b0);
      sendWord(24'h000000, 1'b1);
      drain();

      // Underrun after a non-last word, then a later random word.
      sendWord(24'h800000, 1'b0);
      drain();
      repeat (5) step();
      sendWord(24'($urandom()), 1'b1);
      drain();

      // Next word offered throughout the latch period.
      sendWord(24'($urandom()), 1'b1);
      sendWord(24'($urandom()), 1'b1);
      drain();

      // Reset during the high phase of bit 10, then a full new word.
      sendWord(24'hC3C75A, 1'b0);
      repeat (105) step();
      nResetIN = 1'b0;
      validIN  = 1'b1;
      repeat (2) step();
      nResetIN = 1'b1;
      validIN  = 1'b0;
      step();
      sendWord(24'($urandom()), 1'b1);
      drain();

      // Random stream honouring valid/ready: data held until accepted.
      for (int i = 0; i < 1500; i++) begin
         if (!validIN && $urandom_range(0, 3) == 0) begin
            validIN = 1'b1;
            dataIN  = 24'($urandom());
            lastIN  = ($urandom_range(0, 3) == 0);
         end
         step();
         if (xfer) begin
            if ($urandom_range(0, 1) == 1) begin
               dataIN = 24'($urandom());
               lastIN = ($urandom_range(0, 3) == 0);
            end else begin
               validIN = 1'b0;
            end
         end
      end
      validIN = 1'b0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
